// File: rtl/dsp_mac_pipe_if.sv
// Sample-in / result-out bus of dsp_mac_pipe.
// The master drives samples and the result-ready strobe; the slave is the MAC slice.
interface dsp_mac_pipe_if #(
  parameter int AW = 18,
  parameter int BW = 18,
  parameter int PW = 48
) ();
  logic                 IN_VALID;
  logic                 IN_READY;
  logic signed [AW-1:0] A;
  logic signed [BW-1:0] B;
  logic signed [BW-1:0] D;
  logic signed [PW-1:0] C;
  logic [3:0]           OPMODE;
  logic                 OUT_VALID;
  logic                 OUT_READY;
  logic signed [PW-1:0] P;
  logic                 CARRYOUT;
  logic                 OVERFLOW;

  modport master (
    output IN_VALID, A, B, D, C, OPMODE, OUT_READY,
    input  IN_READY, OUT_VALID, P, CARRYOUT, OVERFLOW
  );

  modport slave (
    input  IN_VALID, A, B, D, C, OPMODE, OUT_READY,
    output IN_READY, OUT_VALID, P, CARRYOUT, OVERFLOW
  );
endinterface

// File: rtl/dsp_mac_pipe.sv
// Pipelined signed MAC slice: pre-adder -> multiplier -> post-adder/accumulator,
// with valid/ready flow control and N-sample dot-product accumulation.
// Optional feature macro: DSP_MAC_SAT_EN (saturate the post-add on signed overflow;
// when undefined the result wraps and OVERFLOW still flags the wrap).
module dsp_mac_pipe #(
  parameter int AW      = 18,
  parameter int BW      = 18,
  parameter int PW      = 48,
  parameter int MREG    = 1,
  parameter int ACC_LEN = 16
) (
  input  logic          CLK,
  input  logic          RSTN,
  dsp_mac_pipe_if.slave bus
);

  localparam int OW = BW + 1;
  localparam int MW = AW + BW + 1;
  localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

`ifdef DSP_MAC_SAT_EN
  // Clamp an overflowed sum toward the sign of the base operand.
  function automatic logic signed [PW-1:0] sat_res(input logic signed [PW-1:0] val,
                                                   input logic ovf, input logic neg);
    if (!ovf) return val;
    return neg ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
  endfunction
`endif

  // A stalled result at the output freezes the whole pipe.
  logic out_vld_q;
  logic en;
  assign en           = !(out_vld_q && !bus.OUT_READY);
  assign bus.IN_READY = en;

  // ---- S1: input registers ----
  logic                 vld_p1_q;
  logic signed [AW-1:0] a_p1_q;
  logic signed [BW-1:0] b_p1_q, d_p1_q;
  logic signed [PW-1:0] c_p1_q;
  logic [3:0]           op_p1_q;

  // S1 valid: an accepted sample or a bubble.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)   vld_p1_q <= 1'b0;
    else if (en) vld_p1_q <= bus.IN_VALID;
  end

  // S1 data capture.
  always_ff @(posedge CLK) begin
    if (en) begin
      a_p1_q  <= bus.A;
      b_p1_q  <= bus.B;
      d_p1_q  <= bus.D;
      c_p1_q  <= bus.C;
      op_p1_q <= bus.OPMODE;
    end
  end

  // ---- S2: pre-adder ----
  logic signed [OW-1:0] pre_d;
  logic                 vld_p2_q;
  logic signed [AW-1:0] a_p2_q;
  logic signed [OW-1:0] pre_p2_q;
  logic signed [PW-1:0] c_p2_q;
  logic [3:0]           op_p2_q;

  assign pre_d = op_p1_q[0] ? (op_p1_q[1] ? (OW'(d_p1_q) - OW'(b_p1_q))
                                          : (OW'(d_p1_q) + OW'(b_p1_q)))
                            : OW'(b_p1_q);

  // S2 valid.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)   vld_p2_q <= 1'b0;
    else if (en) vld_p2_q <= vld_p1_q;
  end

  // S2 data: pre-add result travels with A, C and the opmode.
  always_ff @(posedge CLK) begin
    if (en) begin
      a_p2_q   <= a_p1_q;
      pre_p2_q <= pre_d;
      c_p2_q   <= c_p1_q;
      op_p2_q  <= op_p1_q;
    end
  end

  // ---- S3: multiplier (registered or bypassed) ----
  logic signed [MW-1:0] m_d;
  logic signed [MW-1:0] m_s4;
  logic signed [PW-1:0] c_s4;
  logic [3:0]           op_s4;
  logic                 vld_s4;

  assign m_d = MW'(a_p2_q) * MW'(pre_p2_q);

  if (MREG != 0) begin : g_mreg
    logic                 vld_p3_q;
    logic signed [MW-1:0] m_p3_q;
    logic signed [PW-1:0] c_p3_q;
    logic [3:0]           op_p3_q;

    // S3 valid.
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)   vld_p3_q <= 1'b0;
      else if (en) vld_p3_q <= vld_p2_q;
    end

    // S3 data: product register.
    always_ff @(posedge CLK) begin
      if (en) begin
        m_p3_q  <= m_d;
        c_p3_q  <= c_p2_q;
        op_p3_q <= op_p2_q;
      end
    end

    assign m_s4   = m_p3_q;
    assign c_s4   = c_p3_q;
    assign op_s4  = op_p3_q;
    assign vld_s4 = vld_p3_q;
  end else begin : g_nomreg
    assign m_s4   = m_d;
    assign c_s4   = c_p2_q;
    assign op_s4  = op_p2_q;
    assign vld_s4 = vld_p2_q;
  end

  // ---- S4: post-adder / accumulator ----
  logic signed [PW-1:0] acc_q;
  logic [CW-1:0]        cnt_q;
  logic signed [PW-1:0] p_q;
  logic                 co_q, ovf_q;

  logic signed [PW-1:0] m_ext, base, addend, wrap_d, res_d;
  logic [PW:0]          sum_u;
  logic                 ovf_d, last_d, emit_d;

  // Post-add: pick the base, add or subtract the product, detect overflow.
  always_comb begin
    m_ext  = PW'(m_s4);
    base   = (op_s4[2] && (cnt_q != '0)) ? acc_q : c_s4;
    addend = op_s4[3] ? -m_ext : m_ext;
    sum_u  = op_s4[3] ? ({1'b0, base} - {1'b0, m_ext})
                      : ({1'b0, base} + {1'b0, m_ext});
    wrap_d = sum_u[PW-1:0];
    ovf_d  = (base[PW-1] == addend[PW-1]) && (wrap_d[PW-1] != base[PW-1]);
`ifdef DSP_MAC_SAT_EN
    res_d  = sat_res(wrap_d, ovf_d, base[PW-1]);
`else
    res_d  = wrap_d;
`endif
    last_d = (cnt_q == CW'(ACC_LEN - 1));
    emit_d = vld_s4 && (!op_s4[2] || last_d);
  end

  // S4 registers: result, flags, accumulator and group counter.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      out_vld_q <= 1'b0;
      p_q       <= '0;
      co_q      <= 1'b0;
      ovf_q     <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else if (en) begin
      out_vld_q <= emit_d;
      if (emit_d) begin
        p_q   <= res_d;
        co_q  <= sum_u[PW];
        ovf_q <= ovf_d;
      end
      if (vld_s4) begin
        if (op_s4[2]) begin
          acc_q <= res_d;
          cnt_q <= last_d ? '0 : cnt_q + 1'b1;
        end else begin
          // A plain sample ends any partial group.
          cnt_q <= '0;
        end
      end
    end
  end

  assign bus.OUT_VALID = out_vld_q;
  assign bus.P         = p_q;
  assign bus.CARRYOUT  = co_q;
  assign bus.OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe (MREG=1, ACC_LEN=4) plus an MREG=0 twin for latency.
module tb_dsp_mac_pipe;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  dsp_mac_pipe_if #(.AW(18), .BW(18), .PW(48)) bus ();
  dsp_mac_pipe_if #(.AW(18), .BW(18), .PW(48)) bus0 ();

  dsp_mac_pipe #(.AW(18), .BW(18), .PW(48), .MREG(1), .ACC_LEN(4)) u_dut (
    .CLK(clk), .RSTN(rstn), .bus(bus)
  );

  dsp_mac_pipe #(.AW(18), .BW(18), .PW(48), .MREG(0), .ACC_LEN(4)) u_dut0 (
    .CLK(clk), .RSTN(rstn), .bus(bus0)
  );

  assign bus0.IN_VALID  = bus.IN_VALID;
  assign bus0.A         = bus.A;
  assign bus0.B         = bus.B;
  assign bus0.D         = bus.D;
  assign bus0.C         = bus.C;
  assign bus0.OPMODE    = bus.OPMODE;
  assign bus0.OUT_READY = 1'b1;

  localparam logic signed [63:0] MAXP = (64'sd1 <<< 47) - 64'sd1;
  localparam logic signed [63:0] MINP = -(64'sd1 <<< 47);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input int d, input longint c,
                      input logic [3:0] op);
    bus.A        = 18'(a);
    bus.B        = 18'(b);
    bus.D        = 18'(d);
    bus.C        = 48'(c);
    bus.OPMODE   = op;
    bus.IN_VALID = 1'b1;
    step();
    bus.IN_VALID = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!bus.OUT_VALID && n < 12) begin
      step();
      n++;
    end
    chk({tag, "_vld"}, bus.OUT_VALID, 1);
  endtask

  initial begin
    int vcount;
    logic signed [63:0] pval;

    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b1;
    bus.A = '0; bus.B = '0; bus.D = '0; bus.C = '0; bus.OPMODE = '0;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    step();
    step();
    chk("rst_out_valid", bus.OUT_VALID, 0);
    chk("rst_p", bus.P, 0);
    chk("rst_carry", bus.CARRYOUT, 0);
    chk("rst_ovf", bus.OVERFLOW, 0);
    chk("rst_in_ready", bus.IN_READY, 1);
    rstn = 1'b1;
    step();

    // (3 x (5+4)) + 10 = 37; four cycles to OUT_VALID, three without MREG
    send(3, 4, 5, 10, 4'b0001);
    step();
    chk("lat_m0_early", bus0.OUT_VALID, 0);
    step();
    chk("lat_m1_early", bus.OUT_VALID, 0);
    chk("lat_m0_vld", bus0.OUT_VALID, 1);
    chk("lat_m0_p", bus0.P, 37);
    step();
    chk("lat_m1_vld", bus.OUT_VALID, 1);
    chk("t1_p", bus.P, 37);
    chk("t1_ovf", bus.OVERFLOW, 0);
    step();
    chk("t1_drop", bus.OUT_VALID, 0);

    // -2 x (3-7) + 0 = 8; then 100 - 5x6 = 70
    send(-2, 7, 3, 0, 4'b0011);
    wait_out("t2a");
    chk("t2a_p", bus.P, 8);
    chk("t2a_carry", bus.CARRYOUT, 0);
    send(5, 6, 0, 100, 4'b1000);
    wait_out("t2b");
    chk("t2b_p", bus.P, 70);
    chk("t2b_ovf", bus.OVERFLOW, 0);
    step();

    // Four-sample dot product: 1 + 2+4+6+8 = 21, one output only
    vcount = 0;
    pval   = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i <= 4) begin
        bus.A = 18'(i); bus.B = 18'sd2; bus.D = '0; bus.C = 48'sd1;
        bus.OPMODE = 4'b0100; bus.IN_VALID = 1'b1;
      end else begin
        bus.IN_VALID = 1'b0;
      end
      step();
      if (bus.OUT_VALID) begin
        vcount++;
        pval = bus.P;
      end
    end
    chk("acc_count", vcount, 1);
    chk("acc_p", pval, 21);

    // Back-pressure: products 6, 12, 20 held then drained in order
    bus.OUT_READY = 1'b0;
    send(2, 3, 0, 0, 4'b0000);
    send(3, 4, 0, 0, 4'b0000);
    chk("stall_in_ready_pre", bus.IN_READY, 1);
    send(4, 5, 0, 0, 4'b0000);
    step();
    chk("stall_vld", bus.OUT_VALID, 1);
    chk("stall_p_a", bus.P, 6);
    step();
    step();
    chk("stall_in_ready", bus.IN_READY, 0);
    chk("stall_p_b", bus.P, 6);
    bus.OUT_READY = 1'b1;
    step();
    chk("drain_vld1", bus.OUT_VALID, 1);
    chk("drain_p1", bus.P, 12);
    step();
    chk("drain_vld2", bus.OUT_VALID, 1);
    chk("drain_p2", bus.P, 20);
    step();
    chk("drain_end", bus.OUT_VALID, 0);

    // Reset in the middle of a group discards it
    send(1, 2, 0, 1, 4'b0100);
    send(2, 2, 0, 1, 4'b0100);
    step(); step(); step();
    rstn = 1'b0;
    #1;
    chk("mid_rst_p", bus.P, 0);
    chk("mid_rst_vld", bus.OUT_VALID, 0);
    step();
    rstn = 1'b1;
    vcount = 0;
    pval   = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i <= 4) begin
        bus.A = 18'(i); bus.B = 18'sd2; bus.D = '0; bus.C = 48'sd1;
        bus.OPMODE = 4'b0100; bus.IN_VALID = 1'b1;
      end else begin
        bus.IN_VALID = 1'b0;
      end
      step();
      if (bus.OUT_VALID) begin
        vcount++;
        pval = bus.P;
      end
    end
    chk("post_rst_count", vcount, 1);
    chk("post_rst_p", pval, 21);

    // Positive overflow: (2^47-1) + 1
    send(1, 1, 0, MAXP, 4'b0000);
    wait_out("ovf_pos");
`ifdef DSP_MAC_SAT_EN
    chk("ovf_pos_p", bus.P, MAXP);
`else
    chk("ovf_pos_p", bus.P, MINP);
`endif
    chk("ovf_pos_flag", bus.OVERFLOW, 1);
    chk("ovf_pos_carry", bus.CARRYOUT, 0);
    step();

    // Negative overflow: -2^47 - 1
    send(1, 1, 0, MINP, 4'b1000);
    wait_out("ovf_neg");
`ifdef DSP_MAC_SAT_EN
    chk("ovf_neg_p", bus.P, MINP);
`else
    chk("ovf_neg_p", bus.P, MAXP);
`endif
    chk("ovf_neg_flag", bus.OVERFLOW, 1);
    step();

    // Carry without overflow: -1 + 1 = 0, carry out of bit 47
    send(1, 1, 0, -1, 4'b0000);
    wait_out("carry");
    chk("carry_p", bus.P, 0);
    chk("carry_flag", bus.CARRYOUT, 1);
    chk("carry_ovf", bus.OVERFLOW, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
